// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl
// Double-buffer controller for a pair of 160x120, 3-bit frame buffers.
// It normally passes Painter writes straight through to the back buffer.
// On a CPU swap request it does the following, in order:
//   - holds off new CPU primitive writes,
//   - lets the Painter drain its queue,
//   - waits for vertical blank,
//   - flips front/back,
//   - sweeps the new back buffer to bg_color,
//   - hands the write port back to the Painter.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   swap_req            CPU swap request (only honoured while idle)
//   bg_color[2:0]       colour used to clear the new back buffer
//   queue_empty         Painter primitive queue is empty
//   painter_idle        Painter has no line in flight
//   vblank              vertical blank, synchronous to clk
//   p_addr/p_data/p_we  Painter write port
//   fb_addr/fb_data/fb_we  registered write port to the back buffer
//   front_sel           displayed buffer; back buffer is ~front_sel
//   painter_hold        blocks new CPU primitive writes during a swap
//   swap_busy           swap sequence in progress
//   swap_done           one-cycle pulse at the end of the swap
module fb_swap_ctrl #(
  parameter int FB_WORDS = 19200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swap_req,
  input  logic [2:0]  bg_color,
  input  logic        queue_empty,
  input  logic        painter_idle,
  input  logic        vblank,
  input  logic [14:0] p_addr,
  input  logic [2:0]  p_data,
  input  logic        p_we,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  output logic        front_sel,
  output logic        painter_hold,
  output logic        swap_busy,
  output logic        swap_done
);

  localparam logic [14:0] LAST_ADDR = 15'(FB_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    WAIT_VB = 3'd2,
    CLEAR   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [14:0] fb_addr_q, fb_addr_d;
  logic [2:0]  fb_data_q, fb_data_d;
  logic        fb_we_q, fb_we_d;
  logic        front_sel_q, front_sel_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    fb_we_d     = fb_we_q;
    front_sel_d = front_sel_q;
    hold_d      = hold_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        fb_addr_d = p_addr;
        fb_data_d = p_data;
        fb_we_d   = p_we;
        if (swap_req) begin
          hold_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Keep passing writes so the in-flight line and queued primitives land.
        fb_addr_d = p_addr;
        fb_data_d = p_data;
        fb_we_d   = p_we;
        if (queue_empty && painter_idle) begin
          fb_we_d = 1'b0;
          state_d = WAIT_VB;
        end
      end

      WAIT_VB: begin
        fb_we_d = 1'b0;
        if (vblank) begin
          front_sel_d = ~front_sel_q;
          cnt_d       = '0;
          state_d     = CLEAR;
        end
      end

      CLEAR: begin
        fb_addr_d = cnt_q;
        fb_data_d = bg_color;
        fb_we_d   = 1'b1;
        // The counter parks on the last address rather than stepping past it.
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end

      DONE: begin
        fb_we_d = 1'b0;
        hold_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      fb_we_q     <= 1'b0;
      front_sel_q <= 1'b0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      fb_we_q     <= fb_we_d;
      front_sel_q <= front_sel_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fb_addr      = fb_addr_q;
  assign fb_data      = fb_data_q;
  assign fb_we        = fb_we_q;
  assign front_sel    = front_sel_q;
  assign painter_hold = hold_q;
  assign swap_busy    = busy_q;
  assign swap_done    = done_q;

endmodule

// File: doc/fb_swap_ctrl.md
# fb_swap_ctrl

Double-buffer controller for the 160x120, 3-bit frame buffer pair. It sits between the Painter and the frame-buffer write port and selects which buffer VGA scan-out displays (front) and which the Painter draws into (back). On a CPU swap request it holds new CPU primitive writes and waits for the Painter's queue to drain and for vertical blank. It then flips front/back and clears the new back buffer to a background colour before handing the write port back to the Painter.

## Interface
- FB_WORDS, 19200: pixels per buffer (160*120); must be ≤ 32767.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- swap_req  in  1  CPU request to swap; sampled only in IDLE.
- bg_color  in  3  clear colour; sampled every CLEAR cycle.
- queue_empty  in  1  Painter PRAM queue empty (wrtPtr == rdPtr).
- painter_idle  in  1  Painter in its read1 state with no line in flight.
- vblank  in  1  VGA vertical blank, already synchronous to clk.
- p_addr  in  15  Painter frame-buffer address.
- p_data  in  3  Painter pixel data.
- p_we  in  1  Painter write enable.
- fb_addr  out  15  write address to the back buffer.
- fb_data  out  3  write data.
- fb_we  out  1  write enable; the top level routes it to buffer ~front_sel.
- front_sel  out  1  displayed buffer index; back buffer = ~front_sel.
- painter_hold  out  1  ORed into the CPU-facing full flag; blocks new primitive writes.
- swap_busy  out  1  swap sequence in progress.
- swap_done  out  1  one-cycle pulse when the swap and clear are complete.

## Operation
- Registered outputs.
  - Reset values: fb_addr=0, fb_data=0, fb_we=0, front_sel=0, painter_hold=0, swap_busy=0, swap_done=0.
  - Internal reset: state=IDLE, clear counter=0.
- States: IDLE, DRAIN, WAIT_VB, CLEAR, DONE.
- IDLE
  - Pass-through each edge: fb_addr<=p_addr, fb_data<=p_data, fb_we<=p_we.
  - When swap_req=1: painter_hold<=1, swap_busy<=1, go to DRAIN.
- DRAIN
  - Pass-through continues so the Painter's in-flight line and queued primitives complete.
  - When queue_empty && painter_idle: fb_we<=0, go to WAIT_VB.
- WAIT_VB
  - fb_we held 0; Painter writes are dropped.
  - When vblank=1: front_sel<=~front_sel, counter<=0, go to CLEAR.
- CLEAR
  - Each edge: fb_addr<=counter, fb_data<=bg_color, fb_we<=1, counter<=counter+1.
  - On the edge that issues counter==FB_WORDS-1, go to DONE.
  - Painter inputs are ignored.
- DONE (one cycle)
  - fb_we<=0, painter_hold<=0, swap_busy<=0, swap_done<=1, go to IDLE.
- swap_done is cleared on the next edge.
- swap_req while not in IDLE is dropped; the CPU must wait for swap_done before requesting again.
- A swap_req that is still high in the cycle after DONE starts a new swap.
- Counter is 15 bits. It never exceeds FB_WORDS-1 and does not wrap.
- Reset mid-sequence aborts immediately to the reset values.
  - front_sel returns to 0.
  - A partially cleared buffer is left as-is.

## Timing
- Pass-through latency: 1 cycle, from p_* to fb_*.
- Best case: swap_req high before edge 0, with queue_empty, painter_idle and vblank all high.
  - Edge 0: enter DRAIN; painter_hold=1 and swap_busy=1 are visible after edge 0.
  - Edge 1: enter WAIT_VB.
  - Edge 2: front_sel toggles; enter CLEAR.
  - Edges 3 … 3+FB_WORDS-1: clear writes to addresses 0 … FB_WORDS-1.
  - Edge 3+FB_WORDS: swap_done=1, fb_we=0, painter_hold=0.
- DRAIN and WAIT_VB stretch by any number of cycles. No timeout.
- Exactly one address is written per clear cycle, in ascending order, with no gaps.

## Test plan
- Reset → all outputs 0. Then p_we=1, p_addr=0x1234, p_data=5 → fb_we=1, fb_addr=0x1234, fb_data=5 one cycle later.
- swap_req pulse with all conditions true, bg_color=3, FB_WORDS=19200:
  - front_sel 0→1 after edge 2.
  - 19200 consecutive writes of data 3 to addresses 0…19199.
  - swap_done one cycle high at edge 19203; painter_hold low after it.
- swap_req with queue_empty=0 for 50 cycles while the Painter writes:
  - Painter writes pass through during DRAIN.
  - front_sel is unchanged until queue_empty && painter_idle && vblank.
- vblank low for 100 cycles after the drain:
  - fb_we stays 0 throughout; a p_we pulse is dropped.
  - Swap occurs on the first vblank cycle.
- Second swap_req during CLEAR → ignored; exactly one swap_done. A subsequent request toggles front_sel back to 0.
- Reset asserted at clear address 5000 → next cycle fb_we=0, front_sel=0, swap_busy=0, painter_hold=0, state IDLE.
